// File: rtl/sumador_multiciclo_ctrl.sv
// Multi-cycle W = N*K bit adder sequencer: one N-bit chunk per cycle through a shared adder, LSB first.
// Optional subtraction support (op_sub port) is enabled by defining ADDSEQ_SUB_EN.
module sumador_multiciclo_ctrl #(
    parameter int N = 32,
    parameter int K = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*K-1:0] op_a,
    input  logic [N*K-1:0] op_b,
    input  logic           cin,
`ifdef ADDSEQ_SUB_EN
    input  logic           op_sub,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*K-1:0] result,
    output logic           cout,
    output logic           ovf,
    output logic           busy
);

    localparam int W     = N * K;
    localparam int IDX_W = $clog2(K);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   idx;
    logic               carry_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       b_eff;
    logic [N-1:0]       chunk_a;
    logic [N-1:0]       chunk_b;
    logic [N:0]         sum;
    logic               accept;
    logic               last;

`ifdef ADDSEQ_SUB_EN
    logic op_sub_q;
    assign b_eff = op_sub_q ? ~b_q : b_q;
`else
    assign b_eff = b_q;
`endif

    assign accept  = in_valid && (state == IDLE);
    assign last    = (idx == IDX_W'(K - 1));
    assign chunk_a = a_q[int'(idx) * N +: N];
    assign chunk_b = b_eff[int'(idx) * N +: N];
    // Shared N-bit adder: chunk sum with the chained carry.
    assign sum     = {1'b0, chunk_a} + {1'b0, chunk_b} + {{N{1'b0}}, carry_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (last) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand copies are free-running data registers, loaded only on acceptance.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= op_a;
            b_q <= op_b;
`ifdef ADDSEQ_SUB_EN
            op_sub_q <= op_sub;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            carry_q <= 1'b0;
            result  <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            idx <= '0;
`ifdef ADDSEQ_SUB_EN
            carry_q <= op_sub ? 1'b1 : cin;
`else
            carry_q <= cin;
`endif
        end else if (state == RUN) begin
            result[int'(idx) * N +: N] <= sum[N-1:0];
            if (last) begin
                cout <= sum[N];
                ovf  <= (a_q[W-1] == b_eff[W-1]) && (sum[N-1] != a_q[W-1]);
            end else begin
                carry_q <= sum[N];
                idx     <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sumador_multiciclo_ctrl.sv
// Directed bench for sumador_multiciclo_ctrl at N=8, K=4 (W=32); define ADDSEQ_SUB_EN to add subtraction vectors.
module tb_sumador_multiciclo_ctrl;

    localparam int N = 8;
    localparam int K = 4;
    localparam int W = N * K;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         op_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic         busy;

    int n_applied = 0;
    int n_miss    = 0;

    sumador_multiciclo_ctrl #(.N(N), .K(K)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
`ifdef ADDSEQ_SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] r;
        logic         c;
        logic         o;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_applied++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for out_valid; returns the number of edges taken.
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!out_valid && lat < 20);
    endtask

    task automatic run_op(input vec_t v, input string name, input bit release_out);
        int lat;
        in_valid = 1'b1;
        op_a     = v.a;
        op_b     = v.b;
        cin      = v.cin;
        op_sub   = v.sub;
        tick();
        in_valid = 1'b0;
        op_a     = ~v.a;
        op_b     = ~v.b;
        cin      = ~v.cin;
        check({name, " busy"}, {63'd0, busy}, 64'd1);
        wait_done(lat);
        check({name, " latency"}, 64'(lat), 64'(K));
        check({name, " result"}, {32'd0, result}, {32'd0, v.r});
        check({name, " cout/ovf"}, {62'd0, cout, ovf}, {62'd0, v.c, v.o});
        if (release_out) begin
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check({name, " back to idle"}, {62'd0, in_ready, out_valid}, 64'b10);
        end
    endtask

    initial begin
        int lat;
        vec_t v;
        vt.push_back('{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0});
        vt.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0});
        vt.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1});
        vt.push_back('{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0});
        vt.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1});
        vt.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0});
        vt.push_back('{32'h0000_00FF, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0101, 1'b0, 1'b0});

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; cin = 1'b0; op_sub = 1'b0;
        #1;
        check("reset ctrl", {61'd0, in_ready, out_valid, busy}, 64'b100);
        check("reset data", {30'd0, result, cout, ovf}, 64'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < vt.size(); i++) begin
            run_op(vt[i], $sformatf("vec%0d", i), 1'b1);
        end

        // DONE held with out_ready low; in_valid pulses must be ignored.
        v = '{32'h0102_0304, 32'h1010_1010, 1'b0, 1'b0, 32'h1112_1314, 1'b0, 1'b0};
        run_op(v, "hold", 1'b0);
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            op_a = 32'hDEAD_BEEF;
            op_b = 32'h1234_0000;
            tick();
            check($sformatf("hold c%0d", c),
                  {27'd0, out_valid, in_ready, cout, ovf, busy, result},
                  {27'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1112_1314});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hold release", {62'd0, in_ready, out_valid}, 64'b10);

        // Back-to-back: in_valid held, out_ready held.
        out_ready = 1'b1;
        in_valid = 1'b1; op_a = 32'h0000_1000; op_b = 32'h0000_0234; cin = 1'b0;
        tick();
        op_a = 32'h0F0F_0F0F; op_b = 32'h0101_0101; cin = 1'b1;
        wait_done(lat);
        check("b2b first latency", 64'(lat), 64'(K));
        check("b2b first result", {32'd0, result}, 64'h0000_1234);
        tick();
        check("b2b idle gap", {62'd0, in_ready, busy}, 64'b10);
        tick();
        in_valid = 1'b0;
        check("b2b second accepted", {62'd0, in_ready, busy}, 64'b01);
        wait_done(lat);
        check("b2b second latency", 64'(lat), 64'(K));
        check("b2b second result", {32'd0, result}, 64'h1010_1011);
        tick();
        out_ready = 1'b0;
        check("b2b idle", {63'd0, in_ready}, 64'd1);

        // Reset while idx==2 aborts immediately.
        in_valid = 1'b1; op_a = 32'h0101_0101; op_b = 32'h0101_0101; cin = 1'b0;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        check("pre-abort partial", {48'd0, result[15:0]}, 64'h0202);
        rst = 1'b1;
        #1;
        check("abort ctrl", {61'd0, in_ready, out_valid, busy}, 64'b100);
        check("abort data", {30'd0, result, cout, ovf}, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        v = '{32'd5, 32'd3, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b0};
        run_op(v, "after abort", 1'b1);

`ifdef ADDSEQ_SUB_EN
        v = '{32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        run_op(v, "sub 5-7", 1'b1);
        v = '{32'd7, 32'd5, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
        run_op(v, "sub 7-5", 1'b1);
        v = '{32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        run_op(v, "sub min-1", 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
